// File: rtl/fifo_rd_arb_if.sv
// rtl/fifo_rd_arb_if.sv - FIFO read side and two-consumer grant/data bundle for fifo_rd_arb
interface fifo_rd_arb_if #(
    parameter int DATASIZE = 8
);
    logic                rempty;
    logic [DATASIZE-1:0] rdata;
    logic                rinc;
    logic [1:0]          req;
    logic [1:0]          ready;
    logic [1:0]          gnt;
    logic [DATASIZE-1:0] dout;
    logic [1:0]          dvalid;
    logic                burst_done;

    // master is the arbiter; slave is the FIFO plus the two consumers
    modport master (
        input  rempty, rdata, req, ready,
        output rinc, gnt, dout, dvalid, burst_done
    );

    modport slave (
        output rempty, rdata, req, ready,
        input  rinc, gnt, dout, dvalid, burst_done
    );
endinterface

// File: rtl/fifo_rd_arb.sv
// rtl/fifo_rd_arb.sv - round-robin burst arbiter draining one FIFO read port to two consumers
module fifo_rd_arb #(
    parameter int DATASIZE = 8,
    parameter int BURSTLEN = 4,
    parameter int TIMEOUT  = 8
) (
    input  logic              rclk,
    input  logic              rrst,
    fifo_rd_arb_if.master     bus
);
    localparam int CW = $clog2(BURSTLEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_q, state_d;
    logic                owner_q;
    logic [CW-1:0]       cnt_q;
    logic [TW-1:0]       tcnt_q;
    logic [1:0]          gnt_q;
    logic [1:0]          dvalid_q;
    logic [DATASIZE-1:0] dout_q;
    logic                done_q;

    logic                req_g;
    logic                rdy_g;
    logic                pop;
    logic                starved;
    logic                cnt_hit;
    logic                tcnt_hit;
    logic                release_b;
    logic                grant_idx;

    // owner_q doubles as the last-granted pointer while idle
    always_comb begin
        req_g     = bus.req[owner_q];
        rdy_g     = bus.ready[owner_q];
        pop       = (state_q == BURST) & req_g & rdy_g & ~bus.rempty
                    & (cnt_q < CW'(BURSTLEN));
        starved   = (state_q == BURST) & req_g & bus.rempty;
        cnt_hit   = pop & ((cnt_q + CW'(1)) == CW'(BURSTLEN));
        tcnt_hit  = starved & ((tcnt_q + TW'(1)) == TW'(TIMEOUT));
        release_b = (state_q == BURST) & (cnt_hit | ~req_g | tcnt_hit);
        grant_idx = (bus.req == 2'b11) ? ~owner_q : bus.req[1];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|bus.req) state_d = BURST;
            BURST:   if (release_b) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            owner_q  <= 1'b1;
            cnt_q    <= '0;
            tcnt_q   <= '0;
            gnt_q    <= '0;
            dvalid_q <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q   <= release_b;
            dvalid_q <= pop ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
            if (pop) dout_q <= bus.rdata;

            if (state_q == IDLE) begin
                if (|bus.req) begin
                    owner_q <= grant_idx;
                    gnt_q   <= grant_idx ? 2'b10 : 2'b01;
                    cnt_q   <= '0;
                    tcnt_q  <= '0;
                end
            end else begin
                if (release_b) gnt_q <= '0;
                if (pop) cnt_q <= cnt_q + CW'(1);
                // a stalled cycle with data present is not starvation
                if (starved)          tcnt_q <= tcnt_q + TW'(1);
                else if (!bus.rempty) tcnt_q <= '0;
            end
        end
    end

    assign bus.rinc       = pop;
    assign bus.gnt        = gnt_q;
    assign bus.dvalid     = dvalid_q;
    assign bus.dout       = dout_q;
    assign bus.burst_done = done_q;
endmodule

// File: tb/tb_fifo_rd_arb.sv
// tb/tb_fifo_rd_arb.sv - randomized scoreboard bench for fifo_rd_arb against a queue-based reference model
module tb_fifo_rd_arb;
    localparam int DS = 8;
    localparam int BL = 4;
    localparam int TO = 8;

    logic rclk = 1'b0;
    logic rrst = 1'b1;
    always #5 rclk = ~rclk;

    fifo_rd_arb_if #(.DATASIZE(DS)) bus ();

    fifo_rd_arb #(.DATASIZE(DS), .BURSTLEN(BL), .TIMEOUT(TO)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
    );

    typedef struct {
        int          due;
        logic [1:0]  vld;
        logic [DS-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DS-1:0] fifo[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            next_word = 1;

    bit            m_busy;
    int            m_owner;
    int            m_last;
    int            m_pops;
    int            m_run;
    bit            m_done;
    bit            m_pop;
    logic [1:0]    cur_req;
    logic [1:0]    cur_rdy;
    exp_t          mon_e;

    always @(posedge rclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 1; m_pops = 0; m_run = 0;
        m_done = 0; m_pop = 0;
        sb.delete();
    endtask

    task automatic drive(input logic [1:0] rq, input logic [1:0] rd);
        cur_req    = rq;
        cur_rdy    = rd;
        bus.req    = rq;
        bus.ready  = rd;
        bus.rempty = (fifo.size() == 0);
        bus.rdata  = (fifo.size() != 0) ? fifo[0] : '0;
    endtask

    // Burst rules applied to the observed inputs: who owns the port, whether a word leaves, when the grant ends
    task automatic model_step();
        int exp_gnt;
        exp_gnt = m_busy ? (1 << m_owner) : 0;
        check("gnt", 32'(bus.gnt), 32'(exp_gnt));
        check("burst_done", 32'(bus.burst_done), 32'(m_done));
        m_pop = m_busy && cur_req[m_owner] && cur_rdy[m_owner] && fifo.size() > 0 && m_pops < BL;
        check("rinc", 32'(bus.rinc), 32'(m_pop));
        m_done = 0;
        if (!m_busy) begin
            if (cur_req != 2'b00) begin
                if (cur_req == 2'b11) m_owner = 1 - m_last;
                else                  m_owner = cur_req[1] ? 1 : 0;
                m_last = m_owner;
                m_busy = 1; m_pops = 0; m_run = 0;
            end
        end else begin
            if (m_pop) begin
                m_pops++;
                sb.push_back(exp_t'{due: cyc + 1, vld: 2'(1 << m_owner), data: fifo[0]});
            end
            if (fifo.size() == 0 && cur_req[m_owner]) m_run++;
            else if (fifo.size() > 0)                m_run = 0;
            if ((m_pop && m_pops == BL) || !cur_req[m_owner] || m_run == TO) begin
                m_busy = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic step(input logic [1:0] rq, input logic [1:0] rd, input int npush);
        for (int k = 0; k < npush; k++) begin
            fifo.push_back(DS'(next_word));
            next_word++;
        end
        drive(rq, rd);
        @(negedge rclk);
        model_step();
        @(posedge rclk);
        #1;
        if (m_pop) void'(fifo.pop_front());
    endtask

    task automatic reset_mid();
        @(negedge rclk);
        #2 rrst = 1'b1;
        #1;
        check("rst_rinc", 32'(bus.rinc), 32'd0);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_dvalid", 32'(bus.dvalid), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_burst_done", 32'(bus.burst_done), 32'd0);
        @(posedge rclk);
        #1 rrst = 1'b0;
        model_reset();
    endtask

    always @(negedge rclk) begin
        if (!rrst) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL dvalid_missing: got dvalid 0 expected word %0h at cycle %0d", sb[0].data, sb[0].due);
                void'(sb.pop_front());
            end
            if (bus.dvalid != 2'b00) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL dvalid_unexpected: got dvalid %b dout %0h expected none at cycle %0d",
                             bus.dvalid, bus.dout, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.due != cyc || mon_e.vld !== bus.dvalid || mon_e.data !== bus.dout) begin
                        n_fail++;
                        $display("FAIL dout: got dvalid %b dout %0h at cycle %0d expected dvalid %b dout %0h at cycle %0d",
                                 bus.dvalid, bus.dout, cyc, mon_e.vld, mon_e.data, mon_e.due);
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] rq;
        logic [1:0] rd;
        int         hold;
        int         np;
        bus.req    = 2'b11;
        bus.ready  = 2'b11;
        bus.rempty = 1'b0;
        bus.rdata  = 8'hA5;
        model_reset();
        repeat (2) @(posedge rclk);
        #1;
        check("reset_rinc", 32'(bus.rinc), 32'd0);
        check("reset_gnt", 32'(bus.gnt), 32'd0);
        check("reset_dvalid", 32'(bus.dvalid), 32'd0);
        check("reset_dout", 32'(bus.dout), 32'd0);
        check("reset_burst_done", 32'(bus.burst_done), 32'd0);
        @(posedge rclk);
        #1 rrst = 1'b0;

        // two requesters sharing ten words, ending in a starvation timeout
        step(2'b11, 2'b11, 10);
        repeat (39) step(2'b11, 2'b11, 0);
        repeat (2) step(2'b00, 2'b11, 0);

        // consumer 1 alone against an empty FIFO
        repeat (12) step(2'b10, 2'b11, 0);
        repeat (2) step(2'b00, 2'b11, 0);

        // consumer 0 stalls three cycles mid-burst
        step(2'b01, 2'b01, 8);
        step(2'b01, 2'b01, 0);
        repeat (3) step(2'b01, 2'b00, 0);
        repeat (8) step(2'b01, 2'b01, 0);
        repeat (2) step(2'b00, 2'b11, 0);

        // owner withdraws after two pops
        step(2'b10, 2'b11, 2);
        repeat (2) step(2'b10, 2'b11, 0);
        repeat (3) step(2'b00, 2'b11, 0);

        // reset during the second cycle of a burst
        step(2'b11, 2'b11, 3);
        step(2'b11, 2'b11, 0);
        reset_mid();
        repeat (6) step(2'b11, 2'b11, 0);

        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                rq   = 2'($urandom_range(0, 3));
                hold = $urandom_range(1, 12);
            end
            hold--;
            rd = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            np = 0;
            if (fifo.size() < 24) begin
                if ($urandom_range(0, 9) == 0)      np = $urandom_range(2, 6);
                else if ($urandom_range(0, 2) == 0) np = 1;
            end
            if (i % 997 == 500) reset_mid();
            step(rq, rd, np);
        end

        repeat (4) step(2'b00, 2'b11, 0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_rd_arb.md
FIFO_RD_ARB -- requirements
Module: fifo_rd_arb

Interface
REQ-001 SHALL have parameter DATASIZE, default 8: width of FIFO read data.
REQ-002 SHALL have parameter BURSTLEN, default 4: maximum pops per grant, legal range 1..15.
REQ-003 SHALL have parameter TIMEOUT, default 8: consecutive empty cycles tolerated inside a burst, legal range 1..255.
REQ-004 SHALL have port rclk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rrst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port rempty, input, 1: FIFO empty flag, registered on the read side.
REQ-007 SHALL have port rdata, input, DATASIZE: FIFO read data, valid for the current read address whenever rempty=0.
REQ-008 SHALL have port rinc, output, 1: FIFO pop request, combinational.
REQ-009 SHALL have port req, input, 2: per-consumer read request.
REQ-010 SHALL have port ready, input, 2: per-consumer accept capability.
REQ-011 SHALL have port gnt, output, 2: registered one-hot grant, or 0.
REQ-012 SHALL have port dout, output, DATASIZE: registered popped word.
REQ-013 SHALL have port dvalid, output, 2: registered one-hot flag qualifying dout for the consumer.
REQ-014 SHALL have port burst_done, output, 1: one-cycle pulse when a grant is released.

Function
REQ-015 SHALL implement states IDLE and BURST; BURST holds exactly one owner g.
REQ-016 In IDLE with req!=0, SHALL go to BURST next cycle and set gnt to one-hot g; with req=0, SHALL stay in IDLE with gnt=0.
REQ-017 Arbitration SHALL be round-robin: when both request, g is the consumer not granted last; when one requests, g is that consumer; last-granted updates on entry to BURST.
REQ-018 In BURST, rinc SHALL equal req[g] & ready[g] & ~rempty & (cnt<BURSTLEN); rinc SHALL be 0 in IDLE.
REQ-019 On each cycle with rinc=1, SHALL register dout<=rdata and dvalid<=onehot(g) next cycle; otherwise dvalid<=0 and dout holds.
REQ-020 SHALL count pops in cnt (width covering 0..BURSTLEN), cleared on entry to BURST.
REQ-021 SHALL count consecutive BURST cycles with req[g]=1 and rempty=1 in tcnt; any non-empty cycle clears tcnt.
REQ-022 SHALL leave BURST for IDLE on the edge at which the first of these holds: pop brings cnt to BURSTLEN; req[g]=0 (no pop that cycle); tcnt reaches TIMEOUT.
REQ-023 On leaving BURST, SHALL clear gnt and pulse burst_done=1 for exactly one cycle, the cycle gnt first reads 0.
REQ-024 After release SHALL spend at least one IDLE cycle before re-granting, so two grants never appear back to back.
REQ-025 ready[g]=0 with data present SHALL stall (no pop, no timeout increment, grant held).
REQ-026 req or ready of the non-owner SHALL have no effect during BURST.
REQ-027 rempty rising in the same cycle as a pop SHALL not suppress that pop; the next cycle SHALL see rinc=0.
REQ-028 gnt and dvalid SHALL never have more than one bit set, and dvalid SHALL be set only for the current or just-released owner.

Reset
REQ-029 While rrst=1, SHALL force state=IDLE, gnt=0, dvalid=0, dout=0, burst_done=0, cnt=0, tcnt=0, last-granted=1 (consumer 0 wins first); rinc SHALL be 0.
REQ-030 Reset asserted mid-burst SHALL abort immediately with no burst_done pulse; first grant after release follows REQ-029.

Verification
REQ-031 Reset, req=2'b11, ready=2'b11, FIFO holding 10 words -> gnt=01 for 4 pops, burst_done, IDLE, gnt=10 for 4 pops, then gnt=01 for the last 2 pops and release on timeout after 8 empty cycles.
REQ-032 req=2'b01, ready[0] low for 3 cycles mid-burst, FIFO non-empty -> rinc=0 for those 3 cycles, gnt held, cnt unchanged, burst completes with 4 pops.
REQ-033 req=2'b10, FIFO empty throughout -> gnt=10 for TIMEOUT=8 cycles, zero pops, burst_done pulse, gnt=0.
REQ-034 Burst owner drops req after 2 pops -> release on that edge, exactly 2 dvalid pulses, burst_done once.
REQ-035 Words A,B,C popped -> dout=A,B,C each one cycle after its rinc, dvalid one-hot for the owner, dout order matches FIFO order.
REQ-036 rrst pulsed during cycle 2 of a burst -> all outputs zero asynchronously, no burst_done, next grant with req=11 goes to consumer 0.
